fb_strobe_pixel_writer: RTL

//  Consumer of the software-driven framebuffer strobe bit: synchronises the PIO strobe, detects rising edges, and captures {x,y,color}.

---
 rtl/fb_strobe_pixel_writer_pkg.sv | 18 +
 rtl/fb_strobe_pixel_writer_if.sv | 13 +
 rtl/fb_strobe_pixel_writer_fifo.sv | 45 ++++
 rtl/fb_strobe_pixel_writer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fb_strobe_pixel_writer_pkg.sv
// Shared types and defaults for the framebuffer strobe pixel writer.
// Holds geometry, bus widths, FSM encoding and the queued-request layout.
package fb_pkg;
  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int COLOR_W       = 16;
  localparam int ADDR_W_DEF    = 17;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [COLOR_W-1:0]    color;
  } fb_req_t;
endpackage

// File: rtl/fb_strobe_pixel_writer_if.sv
// Avalon-MM write-only master bus toward the framebuffer SRAM.
interface fb_strobe_pixel_writer_if #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 16
);
  logic [ADDR_W-1:0]  fb_address;
  logic               fb_write;
  logic [COLOR_W-1:0] fb_writedata;
  logic               fb_waitrequest;

  modport master (output fb_address, output fb_write, output fb_writedata, input fb_waitrequest);
  modport slave  (input fb_address, input fb_write, input fb_writedata, output fb_waitrequest);
endinterface

// File: rtl/fb_strobe_pixel_writer_fifo.sv
// Show-ahead synchronous FIFO; extra pointer MSB separates full from empty.
module fb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    // a pop frees the slot, so push-while-full is fine in the same cycle
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    dout    = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/fb_strobe_pixel_writer.sv
// Turns rising edges of the PIO strobe into buffered Avalon-MM pixel writes,
// with range/overflow drop tracking.
module fb_strobe_pixel_writer
  import fb_pkg::*;
#(
  parameter int FB_WIDTH    = FB_WIDTH_DEF,
  parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int CW          = COLOR_W,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        strobe_in,
  input  logic [X_W-1:0]              pix_x,
  input  logic [Y_W-1:0]              pix_y,
  input  logic [CW-1:0]               pix_color,
  input  logic                        clear_err,
  fb_strobe_pixel_writer_if.master    fb,
  output logic                        busy,
  output logic                        err_overflow,
  output logic                        err_range,
  output logic [7:0]                  drop_count
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d, edge_det;
  logic                   cap_vld_q, cap_vld_d, cap_ok_q, cap_ok_d;
  logic [ADDR_W-1:0]      cap_addr_q, cap_addr_d;
  logic [CW-1:0]          cap_color_q, cap_color_d;
  logic                   drop_rng, drop_ovf, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W+CW-1:0]   fifo_dout;
  logic                   err_ovf_q, err_ovf_d, err_rng_q, err_rng_d;
  logic [7:0]             cnt_q, cnt_d;
  fb_state_e              state_q, state_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [CW-1:0]          data_q, data_d;

  // Synchroniser, edge detect and capture; pix_* are sampled in the edge cycle
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], strobe_in};
    hist_d      = sync_q[SYNC_STAGES-1];
    edge_det    = sync_q[SYNC_STAGES-1] & ~hist_q;
    cap_vld_d   = edge_det;
    cap_ok_d    = cap_ok_q;
    cap_addr_d  = cap_addr_q;
    cap_color_d = cap_color_q;
    if (edge_det) begin
      cap_ok_d    = (int'(pix_x) < FB_WIDTH) && (int'(pix_y) < FB_HEIGHT);
      cap_addr_d  = ADDR_W'(pix_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(pix_x);
      cap_color_d = pix_color;
    end
  end

  // Drop classification and sticky error state; a same-cycle drop beats clear_err
  always_comb begin
    drop_rng  = cap_vld_q & ~cap_ok_q;
    drop_ovf  = cap_vld_q & cap_ok_q & fifo_full & ~fifo_pop;
    fifo_push = cap_vld_q & cap_ok_q & ~drop_ovf;
    err_rng_d = drop_rng ? 1'b1 : (clear_err ? 1'b0 : err_rng_q);
    err_ovf_d = drop_ovf ? 1'b1 : (clear_err ? 1'b0 : err_ovf_q);
    if (drop_rng || drop_ovf)
      cnt_d = clear_err ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
    else
      cnt_d = clear_err ? 8'd0 : cnt_q;
  end

  fb_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W+CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cap_addr_q, cap_color_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_WRITE;
      ST_WRITE: if (!fb.fb_waitrequest && fifo_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Refill the output registers on accept so back-to-back writes have no bubble
  always_comb begin
    fifo_pop = !fifo_empty && (state_q == ST_IDLE || !fb.fb_waitrequest);
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (fifo_pop) begin
      {addr_d, data_d} = fifo_dout;
      wr_d             = 1'b1;
    end else if (state_q == ST_WRITE && !fb.fb_waitrequest) begin
      wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      hist_q      <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_ok_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_color_q <= '0;
      err_ovf_q   <= 1'b0;
      err_rng_q   <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      cap_vld_q   <= cap_vld_d;
      cap_ok_q    <= cap_ok_d;
      cap_addr_q  <= cap_addr_d;
      cap_color_q <= cap_color_d;
      err_ovf_q   <= err_ovf_d;
      err_rng_q   <= err_rng_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign fb.fb_write     = wr_q;
  assign fb.fb_address   = addr_q;
  assign fb.fb_writedata = data_q;
  assign busy            = !fifo_empty || wr_q;
  assign err_overflow    = err_ovf_q;
  assign err_range       = err_rng_q;
  assign drop_count      = cnt_q;
endmodule
